// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Sequences the 6502 ALU for memory-operand instructions:
//            operand fetch, one execute cycle, flag commit, RMW double store.
// Revision : 1.0
// ============================================================================
module alu_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_kind,
   input  logic [1:0]  cmd_reg,
   output logic        mem_rd_req,
   input  logic        mem_rd_ack,
   input  logic [7:0]  mem_rdata,
   output logic        mem_wr_req,
   input  logic        mem_wr_ack,
   output logic [7:0]  mem_wdata,
   output logic [10:0] alu_op,
   output logic [7:0]  alu_m,
   output logic        alu_ci,
   output logic        alu_vi,
   input  logic [7:0]  alu_result,
   input  logic        alu_co,
   input  logic        alu_vo,
   input  logic        alu_so,
   input  logic        alu_zo,
   output logic        reg_we,
   output logic [1:0]  reg_sel,
   output logic [7:0]  reg_wdata,
   input  logic        p_load,
   input  logic [3:0]  p_in,
   output logic        flag_c,
   output logic        flag_z,
   output logic        flag_v,
   output logic        flag_n
);

   localparam logic [3:0] K_ORA = 4'd0;
   localparam logic [3:0] K_AND = 4'd1;
   localparam logic [3:0] K_EOR = 4'd2;
   localparam logic [3:0] K_ADC = 4'd3;
   localparam logic [3:0] K_CMP = 4'd4;
   localparam logic [3:0] K_SBC = 4'd5;
   localparam logic [3:0] K_BIT = 4'd6;
   localparam logic [3:0] K_ASL = 4'd7;
   localparam logic [3:0] K_LSR = 4'd8;
   localparam logic [3:0] K_ROL = 4'd9;
   localparam logic [3:0] K_ROR = 4'd10;
   localparam logic [3:0] K_INC = 4'd11;
   localparam logic [3:0] K_DEC = 4'd12;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_EXEC   = 3'd2,
      S_DUMMYW = 3'd3,
      S_WRITE  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_kind;
   logic [1:0]  r_sel;
   logic [7:0]  r_m;
   logic [7:0]  r_w;
   logic        r_rd_req;
   logic        r_wr_req;
   logic [7:0]  r_wdata;
   logic        r_c;
   logic        r_z;
   logic        r_v;
   logic        r_n;

   logic        w_kind_ok;
   logic        w_accept;
   logic [10:0] w_op;
   logic        w_upd_c;
   logic        w_upd_v;
   logic        w_upd_zn;
   logic        w_wr_reg;
   logic        w_rmw;

   assign w_kind_ok = (cmd_kind <= K_DEC);
   assign w_accept  = (r_state == S_IDLE) && cmd_valid;

   // Per-kind ALU op word and which flags / results the execute cycle commits
   always_comb begin
      w_op     = '0;
      w_upd_c  = 1'b0;
      w_upd_v  = 1'b0;
      w_upd_zn = 1'b0;
      w_wr_reg = 1'b0;
      w_rmw    = 1'b0;
      case (r_kind)
         K_ORA: begin
            w_op     = {r_sel, 2'b00, 3'b100, 3'b000, 1'b0};
            w_upd_zn = 1'b1;
            w_wr_reg = 1'b1;
         end
         K_AND: begin
            w_op     = {r_sel, 2'b00, 3'b100, 3'b001, 1'b1};
            w_upd_zn = 1'b1;
            w_wr_reg = 1'b1;
         end
         K_EOR: begin
            w_op     = {r_sel, 2'b00, 3'b100, 3'b010, 1'b0};
            w_upd_zn = 1'b1;
            w_wr_reg = 1'b1;
         end
         K_ADC: begin
            w_op     = {r_sel, 2'b00, 3'b100, 3'b011, 1'b0};
            w_upd_c  = 1'b1;
            w_upd_v  = 1'b1;
            w_upd_zn = 1'b1;
            w_wr_reg = 1'b1;
         end
         K_CMP: begin
            w_op     = {r_sel, 2'b00, 3'b100, 3'b110, 1'b0};
            w_upd_c  = 1'b1;
            w_upd_zn = 1'b1;
         end
         K_SBC: begin
            w_op     = {r_sel, 2'b00, 3'b100, 3'b111, 1'b1};
            w_upd_c  = 1'b1;
            w_upd_v  = 1'b1;
            w_upd_zn = 1'b1;
            w_wr_reg = 1'b1;
         end
         K_BIT: begin
            w_op     = {r_sel, 2'b00, 3'b100, 3'b001, 1'b0};
            w_upd_v  = 1'b1;
            w_upd_zn = 1'b1;
         end
         K_ASL: begin
            w_op     = {2'b00, 2'b00, 3'b000, 3'b100, 1'b0};
            w_upd_c  = 1'b1;
            w_upd_zn = 1'b1;
            w_rmw    = 1'b1;
         end
         K_ROL: begin
            w_op     = {2'b00, 2'b00, 3'b001, 3'b100, 1'b0};
            w_upd_c  = 1'b1;
            w_upd_zn = 1'b1;
            w_rmw    = 1'b1;
         end
         K_LSR: begin
            w_op     = {2'b00, 2'b00, 3'b010, 3'b100, 1'b0};
            w_upd_c  = 1'b1;
            w_upd_zn = 1'b1;
            w_rmw    = 1'b1;
         end
         K_ROR: begin
            w_op     = {2'b00, 2'b00, 3'b011, 3'b100, 1'b0};
            w_upd_c  = 1'b1;
            w_upd_zn = 1'b1;
            w_rmw    = 1'b1;
         end
         K_INC: begin
            w_op     = {2'b00, 2'b00, 3'b111, 3'b100, 1'b0};
            w_upd_zn = 1'b1;
            w_rmw    = 1'b1;
         end
         K_DEC: begin
            w_op     = {2'b00, 2'b00, 3'b110, 3'b100, 1'b0};
            w_upd_zn = 1'b1;
            w_rmw    = 1'b1;
         end
         default: begin
            w_op = '0;
         end
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (cmd_valid && w_kind_ok) w_next = S_READ;
         S_READ:   if (mem_rd_ack) w_next = S_EXEC;
         S_EXEC:   w_next = w_rmw ? S_DUMMYW : S_IDLE;
         S_DUMMYW: if (mem_wr_ack) w_next = S_WRITE;
         S_WRITE:  if (mem_wr_ack) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_kind   <= '0;
         r_sel    <= '0;
         r_m      <= '0;
         r_w      <= '0;
         r_rd_req <= 1'b0;
         r_wr_req <= 1'b0;
         r_wdata  <= '0;
         r_c      <= 1'b0;
         r_z      <= 1'b0;
         r_v      <= 1'b0;
         r_n      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept && w_kind_ok) begin
            r_kind <= cmd_kind;
            r_sel  <= cmd_reg;
         end
         if (r_state == S_READ && mem_rd_ack) begin
            r_m <= mem_rdata;
         end
         if (r_state == S_EXEC) begin
            if (w_upd_c) r_c <= alu_co;
            if (w_upd_v) r_v <= alu_vo;
            if (w_upd_zn) begin
               r_z <= alu_zo;
               r_n <= alu_so;
            end
            if (w_rmw) r_w <= alu_result;
         end
         // Direct flag load only when the idle cycle is not taken by a command
         if (r_state == S_IDLE && !cmd_valid && p_load) begin
            r_n <= p_in[3];
            r_v <= p_in[2];
            r_z <= p_in[1];
            r_c <= p_in[0];
         end
         r_rd_req <= (w_next == S_READ);
         r_wr_req <= (w_next == S_DUMMYW) || (w_next == S_WRITE);
         case (w_next)
            S_DUMMYW: r_wdata <= r_m;
            S_WRITE:  r_wdata <= r_w;
            default:  r_wdata <= '0;
         endcase
      end
   end

   assign cmd_ready  = (r_state == S_IDLE);
   assign mem_rd_req = r_rd_req;
   assign mem_wr_req = r_wr_req;
   assign mem_wdata  = r_wdata;
   assign alu_op     = (r_state == S_EXEC) ? w_op : 11'd0;
   assign alu_m      = r_m;
   assign alu_ci     = r_c;
   assign alu_vi     = r_v;
   assign reg_we     = (r_state == S_EXEC) && w_wr_reg;
   assign reg_sel    = r_sel;
   assign reg_wdata  = alu_result;
   assign flag_c     = r_c;
   assign flag_z     = r_z;
   assign flag_v     = r_v;
   assign flag_n     = r_n;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Directed self-checking bench for alu_sequencer.
// Revision : 1.0
// ============================================================================
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_kind;
   logic [1:0]  cmd_reg;
   logic        mem_rd_req;
   logic        mem_rd_ack = 1'b0;
   logic [7:0]  mem_rdata;
   logic        mem_wr_req;
   logic        mem_wr_ack = 1'b0;
   logic [7:0]  mem_wdata;
   logic [10:0] alu_op;
   logic [7:0]  alu_m;
   logic        alu_ci;
   logic        alu_vi;
   logic [7:0]  alu_result;
   logic        alu_co;
   logic        alu_vo;
   logic        alu_so;
   logic        alu_zo;
   logic        reg_we;
   logic [1:0]  reg_sel;
   logic [7:0]  reg_wdata;
   logic        p_load;
   logic [3:0]  p_in;
   logic        flag_c;
   logic        flag_z;
   logic        flag_v;
   logic        flag_n;

   always #5 clk = ~clk;

   alu_sequencer u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_kind   (cmd_kind),
      .cmd_reg    (cmd_reg),
      .mem_rd_req (mem_rd_req),
      .mem_rd_ack (mem_rd_ack),
      .mem_rdata  (mem_rdata),
      .mem_wr_req (mem_wr_req),
      .mem_wr_ack (mem_wr_ack),
      .mem_wdata  (mem_wdata),
      .alu_op     (alu_op),
      .alu_m      (alu_m),
      .alu_ci     (alu_ci),
      .alu_vi     (alu_vi),
      .alu_result (alu_result),
      .alu_co     (alu_co),
      .alu_vo     (alu_vo),
      .alu_so     (alu_so),
      .alu_zo     (alu_zo),
      .reg_we     (reg_we),
      .reg_sel    (reg_sel),
      .reg_wdata  (reg_wdata),
      .p_load     (p_load),
      .p_in       (p_in),
      .flag_c     (flag_c),
      .flag_z     (flag_z),
      .flag_v     (flag_v),
      .flag_n     (flag_n)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Memory responder and bus monitor share one process so ordering is fixed
   int          rd_wait = 0;
   int          wr_wait = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          rd_cycles = 0;
   int          wr_cycles = 0;
   int          wr_unstable = 0;
   logic        wr_pend = 1'b0;
   logic [7:0]  wr_prev = '0;
   logic [7:0]  store_log [0:63];
   int          store_n = 0;
   int          we_n = 0;
   logic [7:0]  we_data = '0;
   logic [1:0]  we_sel = '0;
   int          op_n = 0;
   logic [10:0] op_last = '0;
   logic [7:0]  m_last = '0;
   logic        ci_last = 1'b0;

   always @(negedge clk) begin
      if (mem_rd_req) begin
         if (rd_cnt == rd_wait) begin mem_rd_ack = 1'b1; rd_cnt = 0; end
         else begin mem_rd_ack = 1'b0; rd_cnt++; end
      end else begin
         mem_rd_ack = 1'b0; rd_cnt = 0;
      end
      if (mem_wr_req) begin
         if (wr_cnt == wr_wait) begin mem_wr_ack = 1'b1; wr_cnt = 0; end
         else begin mem_wr_ack = 1'b0; wr_cnt++; end
      end else begin
         mem_wr_ack = 1'b0; wr_cnt = 0;
      end
      if (mem_rd_req) rd_cycles++;
      if (mem_wr_req) begin
         wr_cycles++;
         if (wr_pend && mem_wdata !== wr_prev) wr_unstable++;
         wr_prev = mem_wdata;
         wr_pend = !mem_wr_ack;
         if (mem_wr_ack && store_n < 64) begin
            store_log[store_n] = mem_wdata;
            store_n++;
         end
      end else begin
         wr_pend = 1'b0;
      end
      if (reg_we) begin we_n++; we_data = reg_wdata; we_sel = reg_sel; end
      if (alu_op != 11'd0) begin
         op_n++; op_last = alu_op; m_last = alu_m; ci_last = alu_ci;
      end
   end

   int b_rd, b_wr, b_st, b_we, b_op, b_un;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic snap();
      b_rd = rd_cycles; b_wr = wr_cycles; b_st = store_n;
      b_we = we_n;      b_op = op_n;      b_un = wr_unstable;
   endtask

   task automatic set_alu(input logic [7:0] m, input logic [7:0] res,
                          input logic co, input logic vo, input logic so, input logic zo);
      mem_rdata = m; alu_result = res;
      alu_co = co; alu_vo = vo; alu_so = so; alu_zo = zo;
   endtask

   task automatic run_cmd(input logic [3:0] k, input logic [1:0] r, output int cyc);
      step();
      cmd_valid = 1'b1; cmd_kind = k; cmd_reg = r;
      step();
      cmd_valid = 1'b0;
      cyc = 1;
      while (!cmd_ready && cyc < 100) begin
         step();
         cyc++;
      end
      chk("cmd_done", 32'(cmd_ready), 1);
   endtask

   function automatic logic [31:0] flags();
      return 32'({flag_n, flag_v, flag_z, flag_c});
   endfunction

   int cyc;
   int k;

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_kind = '0; cmd_reg = '0;
      p_load = 1'b0; p_in = '0;
      set_alu(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) step();
      reset_n = 1'b1;
      step();
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_flags", flags(), 0);
      chk("rst_bus", 32'({mem_rd_req, mem_wr_req, reg_we, reg_sel, mem_wdata, alu_op}), 0);

      // Direct flag load while idle
      p_load = 1'b1; p_in = 4'b1010;
      step();
      p_load = 1'b0;
      chk("pload_idle", flags(), 'b1010);

      // ADC A=0x50 + M=0x50, C=0
      set_alu(8'h50, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0);
      snap();
      run_cmd(4'd3, 2'd0, cyc);
      chk("adc_cycles", 32'(cyc), 3);
      chk("adc_we", 32'(we_n - b_we), 1);
      chk("adc_wdata", 32'(we_data), 'hA0);
      chk("adc_op", 32'(op_last), 'h046);
      chk("adc_m", 32'(m_last), 'h50);
      chk("adc_ci", 32'(ci_last), 0);
      chk("adc_flags", flags(), 'b1100);
      chk("adc_bus", 32'((rd_cycles - b_rd) * 16 + (wr_cycles - b_wr)), 'h10);

      // CMP A=0x10 vs M=0x10: V must hold
      set_alu(8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      snap();
      run_cmd(4'd4, 2'd0, cyc);
      chk("cmp_flags", flags(), 'b0111);
      chk("cmp_we", 32'(we_n - b_we), 0);
      chk("cmp_op", 32'(op_last), 'h04C);

      // SBC X=0x00 - M=0x01, C=1
      set_alu(8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      snap();
      run_cmd(4'd5, 2'd2, cyc);
      chk("sbc_ci", 32'(ci_last), 1);
      chk("sbc_op", 32'(op_last), 'h44F);
      chk("sbc_we", 32'(we_n - b_we), 1);
      chk("sbc_wdata", 32'({we_sel, we_data}), 'h2FF);
      chk("sbc_flags", flags(), 'b1000);

      // BIT A=0x01, M=0xC0: C holds
      set_alu(8'hC0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      snap();
      run_cmd(4'd6, 2'd0, cyc);
      chk("bit_flags", flags(), 'b1110);
      chk("bit_we", 32'(we_n - b_we), 0);
      chk("bit_op", 32'(op_last), 'h042);

      // ROR RMW M=0x01, C=1, two stall cycles on each handshake
      p_load = 1'b1; p_in = 4'b0001;
      step();
      p_load = 1'b0;
      rd_wait = 2; wr_wait = 2;
      set_alu(8'h01, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
      snap();
      run_cmd(4'd10, 2'd0, cyc);
      chk("ror_cycles", 32'(cyc), 11);
      chk("ror_op", 32'(op_last), 'h038);
      chk("ror_ci", 32'(ci_last), 1);
      chk("ror_nstores", 32'(store_n - b_st), 2);
      chk("ror_store0", 32'(store_log[b_st]), 'h01);
      chk("ror_store1", 32'(store_log[b_st + 1]), 'h80);
      chk("ror_stable", 32'(wr_unstable - b_un), 0);
      chk("ror_busy", 32'((rd_cycles - b_rd) * 16 + (wr_cycles - b_wr)), 'h36);
      chk("ror_flags", flags(), 'b1001);
      chk("ror_we", 32'(we_n - b_we), 0);

      // INC of 0xFF, zero-wait
      rd_wait = 0; wr_wait = 0;
      set_alu(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      snap();
      run_cmd(4'd11, 2'd0, cyc);
      chk("inc_cycles", 32'(cyc), 5);
      chk("inc_op", 32'(op_last), 'h078);
      chk("inc_stores", 32'({store_log[b_st], store_log[b_st + 1]}), 'hFF00);
      chk("inc_flags", flags(), 'b0011);

      // Reserved kind with a simultaneous p_load: both dropped
      snap();
      step();
      cmd_valid = 1'b1; cmd_kind = 4'd14; p_load = 1'b1; p_in = 4'b1111;
      step();
      cmd_valid = 1'b0; p_load = 1'b0;
      chk("rsv_ready", 32'(cmd_ready), 1);
      repeat (4) step();
      chk("rsv_activity", 32'((rd_cycles - b_rd) + (wr_cycles - b_wr) + (op_n - b_op)), 0);
      chk("rsv_flags", flags(), 'b0011);

      // p_load during EXEC of an ORA is ignored
      set_alu(8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
      snap();
      step();
      cmd_valid = 1'b1; cmd_kind = 4'd0; cmd_reg = 2'd0;
      step();
      cmd_valid = 1'b0;
      step();
      p_load = 1'b1; p_in = 4'b1111;
      chk("ora_exec_op", 32'(alu_op), 'h040);
      step();
      p_load = 1'b0;
      chk("ora_flags", flags(), 'b0001);
      chk("ora_we", 32'({8'(we_n - b_we), we_data}), 'h0140);

      // Reset in the middle of the WRITE phase of a DEC
      wr_wait = 3;
      set_alu(8'h05, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      cmd_valid = 1'b1; cmd_kind = 4'd12; cmd_reg = 2'd0;
      step();
      cmd_valid = 1'b0;
      k = 0;
      while (!(mem_wr_req && mem_wdata == 8'h04) && k < 50) begin
         step();
         k++;
      end
      chk("dec_reach_write", 32'(k < 50), 1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("midrst_req", 32'({mem_rd_req, mem_wr_req}), 0);
      chk("midrst_flags", flags(), 0);
      chk("midrst_ready", 32'(cmd_ready), 1);
      snap();
      repeat (6) step();
      chk("midrst_nowr", 32'((wr_cycles - b_wr) + (store_n - b_st)), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
